// File: rtl/arb_mux_n_pkg.sv
// Shared constants for the arbitrated N-channel mux: arbitration modes and
// the select-width helper (one bit minimum so a single channel still has a port).
package arb_mux_n_pkg;

  localparam logic ARB_RR    = 1'b0;
  localparam logic ARB_FIXED = 1'b1;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_mux_n_if.sv
// Handshake bundle between N producers, the arbitrated mux and one consumer.
// slave is the mux view; master is the producer/consumer view.
interface arb_mux_n_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4
);
  localparam int SELW = arb_mux_n_pkg::sel_w(NCH);

  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;
  logic                 out_valid;
  logic                 out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

endinterface

// File: rtl/arb_mux_n_rr_arbiter.sv
// Grant selection for the mux: round-robin from ptr, or fixed lowest-index wins.
// Combinational grant; ptr advances one past the winner only when advance is set.
module arb_mux_n_rr_arbiter
  import arb_mux_n_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SELW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NCH-1:0]  req,
  input  logic            mode,
  input  logic            advance,
  output logic [NCH-1:0]  gnt_oh,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);

  logic [SELW-1:0] ptr;
  logic [NCH-1:0]  hi;
  logic            any_hi;

  // Requests at or above ptr win first; otherwise fall back to lowest overall,
  // which together is the circular search ptr, ptr+1, ..., ptr-1.
  always_comb begin
    hi      = '0;
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      hi[i] = req[i] && (mode == ARB_RR) && (i >= int'(ptr));
    end
    any_hi = |hi;
    for (int i = 0; i < NCH; i++) begin
      if (!any && (any_hi ? hi[i] : req[i])) begin
        any       = 1'b1;
        gnt_oh[i] = 1'b1;
        gnt_idx   = SELW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && (mode == ARB_RR)) begin
      ptr <= (int'(gnt_idx) + 1 == NCH) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// N:1 arbitrated mux into a one-entry output register; 1-cycle latency.
// Accepts while empty or draining (full throughput); in_ready all-zero while stalled.
module arb_mux_n
  import arb_mux_n_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int MODE  = 0
) (
  input  logic     clk,
  input  logic     rst_n,
  arb_mux_n_if.slave bus
);

  localparam int SELW = sel_w(NCH);

  logic [NCH-1:0]   gnt_oh;
  logic [SELW-1:0]  gnt_idx;
  logic             any;
  logic             can_load;
  logic             load;
  logic [WIDTH-1:0] sel_word;
  logic [WIDTH-1:0] data_q;
  logic [SELW-1:0]  sel_q;
  logic             valid_q;

  arb_mux_n_rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.in_valid),
    .mode    ((MODE == 1) ? ARB_FIXED : ARB_RR),
    .advance (load),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign can_load     = !valid_q || bus.out_ready;
  assign load         = rst_n && can_load && any;
  assign bus.in_ready = load ? gnt_oh : '0;

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_oh[i]) sel_word = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= sel_word;
      sel_q   <= gnt_idx;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// Scoreboarded bench: three mux configurations (RR 4ch, RR 3ch, fixed 4ch);
// expected words queued at stimulus time, popped by per-DUT output monitors.
module tb_arb_mux_n;

  logic clk = 1'b0;
  logic a_rst, b_rst, c_rst;
  int   checks = 0;
  int   errors = 0;
  logic [9:0] qa[$];
  logic [9:0] qb[$];
  logic [9:0] qc[$];

  always #5 clk = ~clk;

  arb_mux_n_if #(.WIDTH(8), .NCH(4)) ia ();
  arb_mux_n_if #(.WIDTH(8), .NCH(3)) ib ();
  arb_mux_n_if #(.WIDTH(8), .NCH(4)) ic ();

  arb_mux_n #(.WIDTH(8), .NCH(4), .MODE(0)) ua (.clk(clk), .rst_n(a_rst), .bus(ia));
  arb_mux_n #(.WIDTH(8), .NCH(3), .MODE(0)) ub (.clk(clk), .rst_n(b_rst), .bus(ib));
  arb_mux_n #(.WIDTH(8), .NCH(4), .MODE(1)) uc (.clk(clk), .rst_n(c_rst), .bus(ic));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon_a
    logic [9:0] e;
    if (a_rst === 1'b1 && ia.out_valid === 1'b1 && ia.out_ready === 1'b1) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected: got %0h expected none", {ia.out_sel, ia.out_data});
      end else begin
        e = qa.pop_front();
        chk("a_word", {22'd0, ia.out_sel, ia.out_data}, {22'd0, e});
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [9:0] e;
    if (b_rst === 1'b1 && ib.out_valid === 1'b1 && ib.out_ready === 1'b1) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: got %0h expected none", {ib.out_sel, ib.out_data});
      end else begin
        e = qb.pop_front();
        chk("b_word", {22'd0, ib.out_sel, ib.out_data}, {22'd0, e});
      end
    end
  end

  always @(negedge clk) begin : mon_c
    logic [9:0] e;
    if (c_rst === 1'b1 && ic.out_valid === 1'b1 && ic.out_ready === 1'b1) begin
      if (qc.size() == 0) begin
        checks++; errors++;
        $display("FAIL c_unexpected: got %0h expected none", {ic.out_sel, ic.out_data});
      end else begin
        e = qc.pop_front();
        chk("c_word", {22'd0, ic.out_sel, ic.out_data}, {22'd0, e});
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    ia.in_valid = 4'b1111; ia.in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; ia.out_ready = 1'b1;
    ib.in_valid = 3'b000;  ib.in_data = {8'hB2, 8'hB1, 8'hB0};         ib.out_ready = 1'b1;
    ic.in_valid = 4'b0000; ic.in_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0}; ic.out_ready = 1'b1;
    step(); step();

    // Reset with every channel requesting
    chk("rst_valid", {31'd0, ia.out_valid}, 32'd0);
    chk("rst_data",  {24'd0, ia.out_data}, 32'd0);
    chk("rst_sel",   {30'd0, ia.out_sel}, 32'd0);
    chk("rst_ready", {28'd0, ia.in_ready}, 32'd0);
    chk("rst_ptr",   {30'd0, ua.u_arb.ptr}, 32'd0);

    // Round-robin fairness, no bubbles
    a_rst = 1'b1;
    #1;
    chk("rr_first_ready", {28'd0, ia.in_ready}, 32'h1);
    qa.push_back({2'd0, 8'hA0}); qa.push_back({2'd1, 8'hA1});
    qa.push_back({2'd2, 8'hA2}); qa.push_back({2'd3, 8'hA3});
    qa.push_back({2'd0, 8'hA0});
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_valid", {31'd0, ia.out_valid}, 32'd1);
      chk("rr_ready", {28'd0, ia.in_ready}, 32'(1 << ((k + 1) % 4)));
    end
    ia.in_valid = 4'b0000;
    step();
    chk("rr_drain", {31'd0, ia.out_valid}, 32'd0);
    chk("rr_ptr",   {30'd0, ua.u_arb.ptr}, 32'd1);

    // Backpressure while full with 0x55, then drain+reload in one cycle
    ia.in_data  = {8'hA3, 8'h66, 8'h55, 8'hA0};
    ia.in_valid = 4'b0010;
    ia.out_ready = 1'b0;
    qa.push_back({2'd1, 8'h55});
    step();
    chk("bp_full", {31'd0, ia.out_valid}, 32'd1);
    ia.in_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ready", {28'd0, ia.in_ready}, 32'd0);
      chk("bp_data",  {24'd0, ia.out_data}, 32'h55);
      chk("bp_ptr",   {30'd0, ua.u_arb.ptr}, 32'd2);
      step();
    end
    ia.out_ready = 1'b1;
    #1;
    chk("bp_reload_ready", {28'd0, ia.in_ready}, 32'h4);
    qa.push_back({2'd2, 8'h66});
    step();
    chk("bp_reload_valid", {31'd0, ia.out_valid}, 32'd1);
    chk("bp_reload_data",  {24'd0, ia.out_data}, 32'h66);
    ia.in_valid = 4'b0000;
    step();
    chk("bp_empty", {31'd0, ia.out_valid}, 32'd0);

    // Mid-transfer reset drops 0x77
    ia.in_data  = {8'hA3, 8'h66, 8'h55, 8'h77};
    ia.in_valid = 4'b0001;
    ia.out_ready = 1'b0;
    step();
    chk("mr_full", {24'd0, ia.out_data}, 32'h77);
    a_rst = 1'b0;
    ia.in_valid = 4'b0000;
    step();
    chk("mr_valid", {31'd0, ia.out_valid}, 32'd0);
    chk("mr_ptr",   {30'd0, ua.u_arb.ptr}, 32'd0);
    a_rst = 1'b1;
    ia.out_ready = 1'b1;
    step(); step();
    chk("mr_idle", {31'd0, ia.out_valid}, 32'd0);

    // NCH=3 wrap from ptr=2
    b_rst = 1'b1;
    ib.in_valid = 3'b010;
    #1;
    chk("w3_ready0", {29'd0, ib.in_ready}, 32'h2);
    qb.push_back({2'd1, 8'hB1});
    step();
    chk("w3_ptr2", {30'd0, ub.u_arb.ptr}, 32'd2);
    ib.in_valid = 3'b011;
    #1;
    chk("w3_wrap_ready", {29'd0, ib.in_ready}, 32'h1);
    qb.push_back({2'd0, 8'hB0});
    step();
    chk("w3_ptr1", {30'd0, ub.u_arb.ptr}, 32'd1);
    ib.in_valid = 3'b111;
    qb.push_back({2'd1, 8'hB1}); qb.push_back({2'd2, 8'hB2}); qb.push_back({2'd0, 8'hB0});
    for (int k = 0; k < 3; k++) begin
      step();
      chk("w3_valid", {31'd0, ib.out_valid}, 32'd1);
    end
    ib.in_valid = 3'b000;
    step();
    chk("w3_end_ptr", {30'd0, ub.u_arb.ptr}, 32'd1);

    // Fixed priority
    c_rst = 1'b1;
    ic.in_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("fp_ready", {28'd0, ic.in_ready}, 32'h2);
      qc.push_back({2'd1, 8'hC1});
      step();
    end
    ic.in_valid = 4'b1000;
    #1;
    chk("fp_ready3", {28'd0, ic.in_ready}, 32'h8);
    qc.push_back({2'd3, 8'hC3});
    step();
    ic.in_valid = 4'b0000;
    step();
    chk("fp_ptr",   {30'd0, uc.u_arb.ptr}, 32'd0);
    chk("fp_empty", {31'd0, ic.out_valid}, 32'd0);

    step();
    chk("qa_left", qa.size(), 32'd0);
    chk("qb_left", qb.size(), 32'd0);
    chk("qc_left", qc.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
